acc_multiplier_32: RTL and testbench

//  Exact (accurate) signed integer multiplier; reference datapath for the

---
 rtl/acc_multiplier_32.sv | 123 ++++++++++++
 tb/tb_acc_multiplier_32.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/acc_multiplier_32.sv
// acc_multiplier_32: exact signed WIDTH x WIDTH multiplier keeping the low WIDTH product bits.
// Radix-4 Booth partial products are registered, then reduced by a 3:2 CSA tree and a CPA.
module acc_multiplier_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] c
);
  localparam int NPP = WIDTH / 2;
  localparam int PPW = WIDTH + 2;

  logic [NPP*PPW-1:0]   pp_s;
  logic [NPP*PPW-1:0]   pp_r;
  logic                 valid_r;
  logic [WIDTH:0]       b_ext_s;
  logic [PPW-1:0]       a_pos_s;
  logic [PPW-1:0]       a_neg_s;
  logic [PPW-1:0]       a2_pos_s;
  logic [PPW-1:0]       a2_neg_s;
  logic [NPP*WIDTH-1:0] cur_s;
  logic [NPP*WIDTH-1:0] nxt_s;
  logic [WIDTH-1:0]     x_s;
  logic [WIDTH-1:0]     y_s;
  logic [WIDTH-1:0]     z_s;
  logic [WIDTH-1:0]     maj_s;
  logic [WIDTH-1:0]     sum_s;
  logic                 pp_hi_unused_s;
  int                   n_s;
  int                   groups_s;

  // b[-1] is an implicit zero so digit i always reads the 3-bit window starting at bit 2i.
  assign b_ext_s  = {b, 1'b0};
  assign a_pos_s  = {{2{a[WIDTH-1]}}, a};
  assign a_neg_s  = ~a_pos_s + {{(PPW-1){1'b0}}, 1'b1};
  assign a2_pos_s = {a[WIDTH-1], a, 1'b0};
  assign a2_neg_s = ~a2_pos_s + {{(PPW-1){1'b0}}, 1'b1};

  // Booth recoding: each 3-bit window of b selects 0, +/-a or +/-2a.
  always_comb begin
    pp_s = '0;
    for (int i = 0; i < NPP; i++) begin
      case (b_ext_s[2*i +: 3])
        3'b001, 3'b010: pp_s[i*PPW +: PPW] = a_pos_s;
        3'b011:         pp_s[i*PPW +: PPW] = a2_pos_s;
        3'b100:         pp_s[i*PPW +: PPW] = a2_neg_s;
        3'b101, 3'b110: pp_s[i*PPW +: PPW] = a_neg_s;
        default:        pp_s[i*PPW +: PPW] = {PPW{1'b0}};
      endcase
    end
  end

  // The two top bits of every partial product land at or above bit WIDTH once shifted.
  always_comb begin
    pp_hi_unused_s = 1'b0;
    for (int i = 0; i < NPP; i++) begin
      pp_hi_unused_s = pp_hi_unused_s ^ (^pp_r[i*PPW+WIDTH +: 2]);
    end
  end

  // Align rows, compress three-to-two level by level until two remain, then add.
  always_comb begin
    x_s      = '0;
    y_s      = '0;
    z_s      = '0;
    maj_s    = '0;
    nxt_s    = '0;
    groups_s = 0;
    n_s      = NPP;
    for (int i = 0; i < NPP; i++) begin
      cur_s[i*WIDTH +: WIDTH] = pp_r[i*PPW +: WIDTH] << (2*i);
    end
    for (int lvl = 0; lvl < NPP; lvl++) begin
      if (n_s > 2) begin
        groups_s = n_s / 3;
        nxt_s    = '0;
        for (int g = 0; g < NPP / 3; g++) begin
          if (g < groups_s) begin
            x_s   = cur_s[(3*g)*WIDTH +: WIDTH];
            y_s   = cur_s[(3*g+1)*WIDTH +: WIDTH];
            z_s   = cur_s[(3*g+2)*WIDTH +: WIDTH];
            maj_s = (x_s & y_s) | (x_s & z_s) | (y_s & z_s);
            nxt_s[(2*g)*WIDTH +: WIDTH]   = x_s ^ y_s ^ z_s;
            nxt_s[(2*g+1)*WIDTH +: WIDTH] = {maj_s[WIDTH-2:0], 1'b0};
          end else begin
            maj_s = maj_s;
          end
        end
        for (int k = 0; k < 2; k++) begin
          if (3*groups_s + k < n_s) begin
            nxt_s[(2*groups_s+k)*WIDTH +: WIDTH] = cur_s[(3*groups_s+k)*WIDTH +: WIDTH];
          end else begin
            maj_s = maj_s;
          end
        end
        n_s   = n_s - groups_s;
        cur_s = nxt_s;
      end else begin
        n_s = n_s;
      end
    end
    sum_s = cur_s[0 +: WIDTH] + cur_s[WIDTH +: WIDTH];
  end

  // Pipeline registers: partial products and valid, then the final sum and its valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pp_r      <= '0;
      valid_r   <= 1'b0;
      c         <= '0;
      out_valid <= 1'b0;
    end else begin
      pp_r      <= pp_s;
      valid_r   <= in_valid;
      c         <= sum_s;
      out_valid <= valid_r;
    end
  end
endmodule

// File: tb/tb_acc_multiplier_32.sv
// Bench for acc_multiplier_32: directed literal cases plus randomized pairs checked
// against a 64-bit signed product model delayed by two clock edges.
module tb_acc_multiplier_32;
  localparam int W = 32;

  typedef struct packed {
    logic         v;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } item_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic [W-1:0] c;

  int    n_cmp = 0;
  int    n_bad = 0;
  bit    log_en = 1'b0;
  item_t q[$];

  acc_multiplier_32 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .c        (c)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p[W-1:0];
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 3));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = v;
    a        = x;
    b        = y;
    @(negedge clk);
  endtask

  // Model: inputs captured at each edge; the output after an edge is the pair from the edge before.
  always @(posedge clk or negedge rst_n) begin
    item_t it;
    if (!rst_n) begin
      q.delete();
    end else begin
      it.v = in_valid;
      it.a = a;
      it.b = b;
      q.push_back(it);
      if (q.size() > 2) void'(q.pop_front());
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic exp_v;
    #1;
    if (!rst_n) begin
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_c", c, 32'd0);
    end else begin
      exp_v = (q.size() == 2) && q[0].v;
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
      if (exp_v) begin
        check("c", c, ref_mul(q[0].a, q[0].b));
        if (log_en) $display("%h %h %h", q[0].a, q[0].b, c);
      end
    end
  end

  logic [W-1:0] da [7] = '{32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h7FFF_FFFF,
                           32'h0001_0000, 32'h8000_0000, 32'h8000_0000};
  logic [W-1:0] db [7] = '{32'd4, 32'd4, 32'hFFFF_FFFA, 32'd2,
                           32'h0001_0000, 32'hFFFF_FFFF, 32'h8000_0000};
  logic [W-1:0] dc [7] = '{32'd12, 32'hFFFF_FFF4, 32'd42, 32'hFFFF_FFFE,
                           32'd0, 32'h8000_0000, 32'd0};

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    repeat (2) @(negedge clk);
    check("reset_c", c, 32'd0);
    check("reset_ov", {31'b0, out_valid}, 32'd0);
    rst_n = 1'b1;

    check("model_pin_min", ref_mul(32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check("model_pin_neg", ref_mul(32'hFFFF_FFF9, 32'hFFFF_FFFA), 32'd42);

    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, da[i], db[i]);
      cyc(1'b0, '0, '0);
      check($sformatf("dir_c_%0d", i), c, dc[i]);
      check($sformatf("dir_ov_%0d", i), {31'b0, out_valid}, 32'd1);
    end

    cyc(1'b1, 32'd1, 32'd1);
    cyc(1'b1, 32'd2, 32'd3);
    check("b2b_c0", c, 32'd1);
    check("b2b_ov0", {31'b0, out_valid}, 32'd1);
    cyc(1'b1, 32'hFFFF_FFFC, 32'd5);
    check("b2b_c1", c, 32'd6);
    check("b2b_ov1", {31'b0, out_valid}, 32'd1);
    cyc(1'b0, '0, '0);
    check("b2b_c2", c, 32'hFFFF_FFEC);
    check("b2b_ov2", {31'b0, out_valid}, 32'd1);
    cyc(1'b0, '0, '0);
    check("b2b_idle_ov", {31'b0, out_valid}, 32'd0);

    cyc(1'b1, 32'd9, 32'd9);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_c", c, 32'd0);
    check("midrst_ov", {31'b0, out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, '0);
      check("postrst_c", c, 32'd0);
      check("postrst_ov", {31'b0, out_valid}, 32'd0);
    end
    cyc(1'b1, 32'd5, 32'd6);
    cyc(1'b0, '0, '0);
    check("first_after_rst_c", c, 32'd30);
    check("first_after_rst_ov", {31'b0, out_valid}, 32'd1);

    log_en = 1'b1;
    for (int i = 0; i < 50000; i++) begin
      cyc($urandom_range(0, 9) != 0, pick(), pick());
    end
    cyc(1'b0, '0, '0);
    cyc(1'b0, '0, '0);
    log_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
